// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller (drives selects/enables), slave = datapath (drives instruction fields and zero).
// No handshake: all signals are valid every cycle.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [3:0] state;

  modport master (
    input  op, func, zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state
  );

  modport slave (
    output op, func, zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath, plus ALU decode and PC enable.
// Latency: 2-5 cycles per instruction (illegal 2, beq/j 3, R/sw/addi 4, lw 5).
// No backpressure: advances one state per clock; reset aborts any instruction in flight.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     st, nxt;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctl;

  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else       st <= nxt;
  end

  always_comb begin
    nxt      = FETCH;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    case (st)
      FETCH: begin
        nxt     = DECODE;
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (ctl.op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: begin
        nxt     = (ctl.op == OP_SW) ? MEMWR : MEMRD;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        nxt  = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        nxt     = ALUWB;
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        nxt     = ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      // unreachable encodings fall back to FETCH with every enable low
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    aluctl = 3'b010;
    case (aluop)
      2'b01: aluctl = 3'b110;
      2'b10: begin
        case (ctl.func)
          6'b100000: aluctl = 3'b010;
          6'b100010: aluctl = 3'b110;
          6'b100100: aluctl = 3'b000;
          6'b100101: aluctl = 3'b001;
          6'b101010: aluctl = 3'b111;
          default:   aluctl = 3'b010;
        endcase
      end
      default: aluctl = 3'b010;
    endcase
  end

  assign ctl.IorD       = iord;
  assign ctl.MemWrite   = memwrite;
  assign ctl.IRWrite    = irwrite;
  assign ctl.RegDst     = regdst;
  assign ctl.MemtoReg   = memtoreg;
  assign ctl.RegWrite   = regwrite;
  assign ctl.ALUSrcA    = alusrca;
  assign ctl.ALUSrcB    = alusrcb;
  assign ctl.ALUControl = aluctl;
  assign ctl.PCSrc      = pcsrc;
  // zero only matters while branch is high, i.e. in BEQEX
  assign ctl.PCEn       = pcwrite | (branch & ctl.zero);
  assign ctl.state      = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed test of multicycle_controller: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       pcen;
  } exp_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   step_no = 0;

  multicycle_controller_if ctl();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  // Expected Moore outputs per state, straight from the state table.
  function automatic exp_t exp_for(input logic [3:0] st, input logic [5:0] f, input logic z);
    exp_t e;
    e = '0;
    e.state  = st;
    e.aluctl = 3'b010;
    case (st)
      4'd0: begin e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      4'd1: e.alusrcb = 2'b11;
      4'd2, 4'd9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd3: e.iord = 1'b1;
      4'd4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      4'd5: begin e.iord = 1'b1; e.memwrite = 1'b1; end
      4'd6: begin
        e.alusrca = 1'b1;
        case (f)
          6'b100010: e.aluctl = 3'b110;
          6'b100100: e.aluctl = 3'b000;
          6'b100101: e.aluctl = 3'b001;
          6'b101010: e.aluctl = 3'b111;
          default:   e.aluctl = 3'b010;
        endcase
      end
      4'd7: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      4'd8: begin e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      4'd10: e.regwrite = 1'b1;
      4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Apply one cycle of inputs, record what the DUT must show this cycle, advance.
  task automatic step(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r);
    ctl.op   = o;
    ctl.func = f;
    ctl.zero = z;
    reset    = r;
    q.push_back(exp_for(st, f, z));
    @(posedge clk);
    #1;
  endtask

  // seq holds up to six expected states, first one in the top nibble.
  // zero is random except in BEQEX; rst_at selects a cycle to assert reset (-1 = none).
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic zb,
                     input int n, input logic [23:0] seq, input int rst_at);
    logic [3:0] s;
    logic       z;
    for (int i = 0; i < n; i++) begin
      s = seq[23-4*i -: 4];
      z = (s == 4'd8) ? zb : 1'($urandom_range(0, 1));
      step(s, o, f, z, (i == rst_at));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{state: ctl.state, iord: ctl.IorD, memwrite: ctl.MemWrite, irwrite: ctl.IRWrite,
            regdst: ctl.RegDst, memtoreg: ctl.MemtoReg, regwrite: ctl.RegWrite,
            alusrca: ctl.ALUSrcA, alusrcb: ctl.ALUSrcB, aluctl: ctl.ALUControl,
            pcsrc: ctl.PCSrc, pcen: ctl.PCEn};
      total++;
      step_no++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle%0d: got state=%0d iord=%b mw=%b irw=%b rdst=%b m2r=%b rw=%b srca=%b srcb=%b alu=%b pcsrc=%b pcen=%b, want state=%0d iord=%b mw=%b irw=%b rdst=%b m2r=%b rw=%b srca=%b srcb=%b alu=%b pcsrc=%b pcen=%b",
                 step_no, a.state, a.iord, a.memwrite, a.irwrite, a.regdst, a.memtoreg,
                 a.regwrite, a.alusrca, a.alusrcb, a.aluctl, a.pcsrc, a.pcen,
                 e.state, e.iord, e.memwrite, e.irwrite, e.regdst, e.memtoreg,
                 e.regwrite, e.alusrca, e.alusrcb, e.aluctl, e.pcsrc, e.pcen);
      end
    end
  end

  initial begin
    ctl.op   = OP_BAD;
    ctl.func = 6'b000000;
    ctl.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, then a lw aborted by reset while in MEMRD
    run(OP_LW, 6'b0, 1'b0, 4, 24'h012300, 3);
    run(OP_LW, 6'b0, 1'b0, 5, 24'h012340, -1);
    run(OP_SW, 6'b0, 1'b0, 4, 24'h012500, -1);
    run(OP_R, 6'b101010, 1'b0, 4, 24'h016700, -1);
    run(OP_R, 6'b100000, 1'b1, 4, 24'h016700, -1);
    run(OP_R, 6'b100010, 1'b0, 4, 24'h016700, -1);
    run(OP_R, 6'b100100, 1'b1, 4, 24'h016700, -1);
    run(OP_R, 6'b100101, 1'b0, 4, 24'h016700, -1);
    run(OP_R, 6'b111111, 1'b0, 4, 24'h016700, -1);
    run(OP_BEQ, 6'b100101, 1'b1, 3, 24'h018000, -1);
    run(OP_BEQ, 6'b100101, 1'b0, 3, 24'h018000, -1);
    run(OP_ADDI, 6'b0, 1'b0, 4, 24'h019A00, -1);
    run(OP_J, 6'b0, 1'b0, 3, 24'h01B000, -1);
    run(OP_BAD, 6'b0, 1'b0, 2, 24'h010000, -1);
    run(OP_LW, 6'b0, 1'b0, 1, 24'h000000, -1);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle MIPS datapath: sequences a shared memory, a shared ALU and the instruction/data registers across several clock steps per instruction. It decodes the opcode and funct fields of the instruction register and drives every datapath select and write enable each cycle. It sits beside the multicycle datapath and replaces the combinational single-cycle control path in that configuration.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; forces state to FETCH
- op  input  6  instr[31:26] from the instruction register
- func  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag, same cycle
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  write register: 0 = rt, 1 = rd
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = Data register
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  output  3  ALU operation
- PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC load enable
- state  output  4  current state encoding, for debug and the bench

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Encodings 12–15 are unreachable; if entered, next state is FETCH with all enables 0.
- Transitions: FETCH→DECODE. DECODE→MEMADR (lw/sw), EXECUTE (R), BEQEX (beq), ADDIEX (addi), JEX (j), FETCH (any other opcode, no writes). MEMADR→MEMRD (lw) / MEMWR (sw). MEMRD→MEMWB. EXECUTE→ALUWB. ADDIEX→ADDIWB. MEMWB, MEMWR, ALUWB, ADDIWB, BEQEX, JEX→FETCH.
- Moore outputs per state; every output not listed is 0, including IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc:
  - FETCH: ALUSrcB=01, ALUOp=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1. MEMWR: IorD=1, MemWrite=1.
  - MEMWB: MemtoReg=1, RegWrite=1. ALUWB: RegDst=1, RegWrite=1. ADDIWB: RegWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - BEQEX: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - JEX: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & zero); the only output depending on a data input besides ALUControl.
- ALU decode: ALUOp 00→010 (add), 01→110 (sub), 10→by func: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other func→010. ALUOp 11 is never generated; it decodes to 010.
- Unsupported func in EXECUTE still proceeds to ALUWB (no trap).

## Timing
- Reset: on a rising edge with reset=1, state←FETCH regardless of current state; mid-instruction work is abandoned, and the partial instruction never reaches its write-back state. While state=FETCH after reset, outputs are FETCH values.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Writes take effect on the rising edge closing the asserting state; exactly one RegWrite/MemWrite cycle per instruction that writes.
- zero is sampled combinationally in BEQEX only; glitches in other states have no effect.

## Test plan
- Reset mid-lw: assert reset in MEMRD → next edge state=0, then IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010, all other enables 0.
- lw (op=100011) from FETCH → state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with MemtoReg=1 and RegDst=0; IorD=1 in state 3.
- sw then R-type: sw → 0,1,2,5,0 with MemWrite=1 only in 5; R-type with func=101010 → 0,1,6,7,0, ALUControl=111 in 6, RegDst=1 and RegWrite=1 in 7.
- beq: op=000100, zero=1 in BEQEX → PCEn=1, PCSrc=01, ALUControl=110. Repeat with zero=0 → PCEn=0; both return to FETCH after 3 cycles.
- addi, then j: addi → 0,1,9,10,0 with ALUSrcB=10 in 9 and RegWrite=1, RegDst=0 in 10. j → 0,1,11,0 with PCSrc=10, PCEn=1 in 11.
- Illegal opcode 111111 → 0,1,0; no RegWrite, MemWrite or PCEn asserted in DECODE. Toggle zero randomly in non-BEQEX states → PCEn matches PCWrite exactly.
